jk_bank_seq: RTL and testbench

JK_BANK_SEQ -- requirements
Module: jk_bank_seq

---
 rtl/jk_bank_pkg.sv | 19 +
 rtl/jk_cell.sv | 24 ++
 rtl/jk_bank_seq.sv | 150 +++++++++++++++
 tb/tb_jk_bank_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/jk_bank_pkg.sv
// Shared definitions for the JK bank sequencer: command encodings and FSM states.
package jk_bank_pkg;

    localparam logic [2:0] CMD_HOLD = 3'b000;
    localparam logic [2:0] CMD_CLR  = 3'b001;
    localparam logic [2:0] CMD_LOAD = 3'b010;
    localparam logic [2:0] CMD_UP   = 3'b011;
    localparam logic [2:0] CMD_DOWN = 3'b100;
    localparam logic [2:0] CMD_SHL  = 3'b101;
    localparam logic [2:0] CMD_CPL  = 3'b110;
    localparam logic [2:0] CMD_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop: 00 hold, 01 clear, 10 set, 11 toggle; synchronous active-high reset.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    // JK next-state function, reset wins
    always_ff @(posedge clk) begin
        if (rst) begin
            q_o <= 1'b0;
        end else begin
            case ({j_i, k_i})
                2'b01:   q_o <= 1'b0;
                2'b10:   q_o <= 1'b1;
                2'b11:   q_o <= ~q_o;
                default: q_o <= q_o;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_seq.sv
// JK bank sequencer: accepts a command, then applies it to a bank of WIDTH JK
// cells for len steps. The controller only computes j/k for each cell.
// Optional feature macro: JK_BANK_SEQ_WRAP_EN adds a wrap output and ends a
// count command at the step that wraps.
module jk_bank_seq
    import jk_bank_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LENW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       cmd,
    input  logic [LENW-1:0]  len,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             busy,
`ifdef JK_BANK_SEQ_WRAP_EN
    output logic             wrap,
`endif
    output logic             done
);

    state_e           state_q;
    logic [2:0]       cmd_q;
    logic [LENW-1:0]  rem_q;     // steps still to apply
    logic [WIDTH-1:0] d_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] cell_q;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;
    logic [WIDTH-1:0] up_t;      // toggle enables for increment
    logic [WIDTH-1:0] dn_t;      // toggle enables for decrement
    logic [WIDTH-1:0] shl_src;
    logic             step_en;
    logic             wrap_hit;

    // A step is applied on every RUN edge unless the command had zero length
    assign step_en = (state_q == ST_RUN) && (rem_q != '0);
    assign shl_src = {cell_q[WIDTH-2:0], d_q[0]};

`ifdef JK_BANK_SEQ_WRAP_EN
    logic wrap_q;
    // Count step that rolls over the whole bank
    assign wrap_hit = step_en &&
                      (((cmd_q == CMD_UP)   && (&cell_q)) ||
                       ((cmd_q == CMD_DOWN) && (~|cell_q)));
    assign wrap = wrap_q;

    // Wrap flag is visible for the one cycle following the wrapping step
    always_ff @(posedge clk) begin
        if (rst) wrap_q <= 1'b0;
        else     wrap_q <= wrap_hit;
    end
`else
    assign wrap_hit = 1'b0;
`endif

    // Ripple carry/borrow chains: bit i toggles when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] &  cell_q[i-1];
            dn_t[i] = dn_t[i-1] & ~cell_q[i-1];
        end
    end

    // j/k drive per command; every cell holds outside of an active step
    always_comb begin
        j_d = '0;
        k_d = '0;
        if (step_en) begin
            case (cmd_q)
                CMD_CLR:  begin j_d = '0;       k_d = '1;       end
                CMD_LOAD: begin j_d = d_q;      k_d = ~d_q;     end
                CMD_UP:   begin j_d = up_t;     k_d = up_t;     end
                CMD_DOWN: begin j_d = dn_t;     k_d = dn_t;     end
                CMD_SHL:  begin j_d = shl_src;  k_d = ~shl_src; end
                CMD_CPL:  begin j_d = '1;       k_d = '1;       end
                default:  begin j_d = '0;       k_d = '0;       end
            endcase
        end
    end

    // Controller FSM with registered busy/done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_HOLD;
            rem_q   <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cmd_q   <= cmd;
                        rem_q   <= len;
                        d_q     <= d;
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (rem_q == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        rem_q <= rem_q - LENW'(1);
                        if ((rem_q == LENW'(1)) || wrap_hit) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j_i (j_d[g]),
            .k_i (k_d[g]),
            .q_o (cell_q[g])
        );
    end

    assign q    = cell_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_jk_bank_seq.sv
// Self-checking bench for jk_bank_seq (WIDTH=4): directed cases plus randomized
// commands checked cycle by cycle against an arithmetic model of the bank.
module tb_jk_bank_seq;

    localparam int W    = 4;
    localparam int LENW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      cmd;
    logic [LENW-1:0] len;
    logic [W-1:0]    d;
    logic [W-1:0]    q;
    logic            busy;
    logic            done;
`ifdef JK_BANK_SEQ_WRAP_EN
    logic            wrap;
`endif

    int nchk = 0;
    int nerr = 0;
    logic [W-1:0] mq;   // model of the bank contents

    jk_bank_seq #(.WIDTH(W), .LENW(LENW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .cmd   (cmd),
        .len   (len),
        .d     (d),
        .q     (q),
        .busy  (busy),
`ifdef JK_BANK_SEQ_WRAP_EN
        .wrap  (wrap),
`endif
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next bank value for one step of a command, as plain arithmetic
    function automatic logic [W-1:0] mstep(input logic [2:0] c, input logic [W-1:0] qv,
                                           input logic [W-1:0] dv);
        int m;
        m = (1 << W);
        case (c)
            3'd1:    return '0;
            3'd2:    return dv;
            3'd3:    return W'((int'(qv) + 1) % m);
            3'd4:    return W'((int'(qv) + m - 1) % m);
            3'd5:    return W'(((int'(qv) * 2) + int'(dv[0])) % m);
            3'd6:    return W'((m - 1) - int'(qv));
            default: return qv;
        endcase
    endfunction

    function automatic bit mwraps(input logic [2:0] c, input logic [W-1:0] qv);
        return ((c == 3'd3) && (int'(qv) == (1 << W) - 1)) || ((c == 3'd4) && (qv == '0));
    endfunction

    // Issue one command and check every cycle until back in IDLE
    task automatic run_cmd(input logic [2:0] c, input int l, input logic [W-1:0] dv,
                           input bit noise);
        int  k;
        bit  fin;
        bit  wr;
        @(negedge clk);
        start = 1'b1; cmd = c; len = LENW'(l); d = dv;
        @(negedge clk);
        start = 1'b0;
        chk("acc_busy", 32'(busy), 32'd1);
        chk("acc_done", 32'(done), 32'd0);
        chk("acc_q", 32'(q), 32'(mq));
        k = 0;
        fin = 1'b0;
        while (!fin) begin
            k++;
            if (noise) begin
                start = 1'($urandom); cmd = 3'($urandom); len = LENW'($urandom); d = W'($urandom);
            end
            @(negedge clk);
            wr = 1'b0;
            if (l != 0) begin
                wr = mwraps(c, mq);
                mq = mstep(c, mq, dv);
            end
            fin = (l == 0) || (k == l);
`ifdef JK_BANK_SEQ_WRAP_EN
            fin = fin || wr;
            chk("run_wrap", 32'(wrap), 32'(wr));
`endif
            chk("run_q", 32'(q), 32'(mq));
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'(fin));
        end
        @(negedge clk);
        start = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_q", 32'(q), 32'(mq));
`ifdef JK_BANK_SEQ_WRAP_EN
        chk("idle_wrap", 32'(wrap), 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cmd = '0; len = '0; d = '0;
        mq = '0;
        repeat (2) @(negedge clk);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Load 1010, len 1
        run_cmd(3'd2, 1, 4'b1010, 1'b0);
        chk("load_val", 32'(q), 32'hA);
        // Count up through the wrap from 1110
        run_cmd(3'd2, 1, 4'b1110, 1'b0);
        run_cmd(3'd3, 3, 4'b0000, 1'b0);
        // Count down from 0000
        run_cmd(3'd1, 1, 4'b0000, 1'b0);
        run_cmd(3'd4, 2, 4'b0000, 1'b0);
        chk("down_val", 32'(q), 32'hE);
        // Complement of 0110
        run_cmd(3'd2, 1, 4'b0110, 1'b0);
        run_cmd(3'd6, 1, 4'b0000, 1'b0);
        chk("cpl_val", 32'(q), 32'h9);
        // Shift left of 0011 with serial-in 1
        run_cmd(3'd2, 1, 4'b0011, 1'b0);
        run_cmd(3'd5, 2, 4'b0001, 1'b0);
        chk("shl_val", 32'(q), 32'hF);
        // Zero-length clear leaves q alone; start pulses during RUN are ignored
        run_cmd(3'd1, 0, 4'b0000, 1'b0);
        chk("len0_val", 32'(q), 32'hF);
        run_cmd(3'd7, 5, 4'b0101, 1'b1);

        // Reset mid-run after three count-up steps
        run_cmd(3'd1, 1, 4'b0000, 1'b0);
        @(negedge clk);
        start = 1'b1; cmd = 3'd3; len = LENW'(8); d = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_q3", 32'(q), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mq = '0;
        chk("mid_rst_q", 32'(q), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end

        // Start coincident with reset is dropped
        run_cmd(3'd2, 1, 4'b1100, 1'b0);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; cmd = 3'd6; len = LENW'(1); d = '0;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        mq = '0;
        chk("rst_start_q", 32'(q), 32'd0);
        chk("rst_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rst_start_busy2", 32'(busy), 32'd0);
        chk("rst_start_q2", 32'(q), 32'd0);

        // Randomized commands with junk inputs while busy
        for (int n = 0; n < 150; n++) begin
            run_cmd(3'($urandom_range(0, 7)), int'($urandom_range(0, 7)), W'($urandom), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
